// File: rtl/led_fade_driver.sv
// LED fade driver: ramps each LED's brightness toward its commanded state at a
// fixed step rate and renders it with a shared PWM counter.
module led_fade_driver #(
  parameter int N_LEDS   = 8,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] led_cmd,
  output logic [N_LEDS-1:0] led_out,
  output logic              fading
);

  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam int                  DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);

  // Saturating one-step move toward the commanded extreme; never wraps.
  function automatic logic [PWM_BITS-1:0] level_step(input logic [PWM_BITS-1:0] lvl,
                                                     input logic                up);
    if (up)
      return (lvl == MAX) ? lvl : lvl + PWM_BITS'(1);
    else
      return (lvl == '0) ? lvl : lvl - PWM_BITS'(1);
  endfunction

  logic [N_LEDS-1:0]   cmd_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [PWM_BITS-1:0] level [N_LEDS];
  logic                step_tick;
  logic [N_LEDS-1:0]   led_nxt;
  logic [N_LEDS-1:0]   off_target;

  assign step_tick = (div_cnt == DIV_LAST);

  // Render stage: full level is solid on so there is no PWM gap at MAX.
  always_comb begin
    led_nxt    = '0;
    off_target = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      led_nxt[i]    = (level[i] == MAX) || (level[i] > pwm_cnt);
      off_target[i] = (level[i] != (cmd_q[i] ? MAX : '0));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q   <= '0;
      pwm_cnt <= '0;
      div_cnt <= '0;
      led_out <= '0;
      fading  <= 1'b0;
      for (int i = 0; i < N_LEDS; i++)
        level[i] <= '0;
    end else begin
      cmd_q   <= led_cmd;
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      div_cnt <= step_tick ? '0 : div_cnt + DIV_W'(1);
      led_out <= led_nxt;
      fading  <= |off_target;
      // Steps use the already-registered command, so a fresh edge waits a tick.
      for (int i = 0; i < N_LEDS; i++)
        if (step_tick)
          level[i] <= level_step(level[i], cmd_q[i]);
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboarded bench for led_fade_driver: a time-based reference model predicts
// every cycle's led_out/fading; a monitor checks the DUT against the queue.
module tb_led_fade_driver;

  localparam int N    = 8;
  localparam int PB   = 4;
  localparam int SD   = 4;
  localparam int MAXV = (1 << PB) - 1;
  localparam int PER  = 1 << PB;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] led_cmd = '0;
  logic [N-1:0] led_out;
  logic         fading;

  led_fade_driver #(.N_LEDS(N), .PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .clk     (clk),
    .reset   (reset),
    .led_cmd (led_cmd),
    .led_out (led_out),
    .fading  (fading)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] led;
    logic         fad;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference state: elapsed cycles since reset, commanded targets, integer levels.
  int           m_t;
  logic [N-1:0] m_cmd_q;
  int           m_level [N];
  logic [N-1:0] m_led_out;
  logic         m_fading;

  task automatic model_edge(input logic [N-1:0] cmd, input logic rst);
    logic [N-1:0] nled;
    logic         nfad;
    int           pwm;
    bit           step;
    if (rst) begin
      m_t = 0; m_cmd_q = '0; m_led_out = '0; m_fading = 1'b0;
      for (int i = 0; i < N; i++) m_level[i] = 0;
      return;
    end
    pwm  = m_t % PER;
    step = ((m_t % SD) == SD - 1);
    nled = '0;
    nfad = 1'b0;
    for (int i = 0; i < N; i++) begin
      int target;
      target  = m_cmd_q[i] ? MAXV : 0;
      nled[i] = (m_level[i] == MAXV) || (m_level[i] > pwm);
      if (m_level[i] != target) nfad = 1'b1;
      if (step) begin
        if (m_level[i] < target) m_level[i] = m_level[i] + 1;
        else if (m_level[i] > target) m_level[i] = m_level[i] - 1;
      end
    end
    m_led_out = nled;
    m_fading  = nfad;
    m_cmd_q   = cmd;
    m_t       = m_t + 1;
  endtask

  task automatic tick(input logic [N-1:0] cmd, input logic rst);
    exp_t e;
    @(negedge clk);
    led_cmd = cmd;
    reset   = rst;
    model_edge(cmd, rst);
    e.led = m_led_out;
    e.fad = m_fading;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [N-1:0] cmd, input int n);
    for (int k = 0; k < n; k++) tick(cmd, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle; check each one against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (led_out !== e.led) begin
          n_bad++;
          $display("FAIL led_out cyc=%0d got=%h exp=%h", cyc, led_out, e.led);
        end
        n_cmp++;
        if (fading !== e.fad) begin
          n_bad++;
          $display("FAIL fading cyc=%0d got=%b exp=%b", cyc, fading, e.fad);
        end
      end
    end
  end

  initial begin
    int guard;
    logic [N-1:0] rc;

    // Reset held with all commands on: outputs must stay dark.
    for (int k = 0; k < 3; k++) tick(8'hFF, 1'b1);

    // Single LED ramps fully up, then sits solid on.
    hold(8'h01, MAXV * SD + SD + 8);

    // Ramp LED3 to 7, then reverse it down to 0.
    guard = 0;
    while (m_level[3] != 7 && guard < 200) begin
      tick(8'h09, 1'b0);
      guard++;
    end
    n_cmp++;
    if (m_level[3] != 7) begin
      n_bad++;
      $display("FAIL reach_level7 got=%0d exp=7", m_level[3]);
    end
    hold(8'h00, MAXV * SD + SD + 8);

    // Glitch: one-cycle pulse on LED5 placed right after a step tick.
    guard = 0;
    while ((m_t % SD) != 0 && guard < 2 * SD) begin
      tick(8'h00, 1'b0);
      guard++;
    end
    tick(8'h20, 1'b0);
    hold(8'h00, 3 * PER);

    // Mixed pattern held long enough to pin every channel at its extreme.
    hold(8'hA5, 2 * MAXV * SD + PER);

    // New ramp interrupted by reset, then recovery.
    hold(8'hFF, 5 * SD + 1);
    tick(8'hFF, 1'b1);
    hold(8'hFF, 3 * SD + PER);

    // Randomized commands, sprinkled with short pulses and occasional resets.
    rc = 8'($urandom);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) rc = 8'($urandom);
      if ($urandom_range(0, 29) == 0) rc = rc ^ (8'd1 << $urandom_range(0, N - 1));
      tick(rc, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
    end
    hold(rc, 4);

    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Drives the board LEDs from the 8-bit output register of the LED PIO peripheral. Each command bit sets its LED's target state. Instead of switching the pin hard, the block ramps a per-LED brightness level up or down at a fixed rate and renders it with a shared PWM counter. It sits between the PIO's output port and the top-level LED pins, in the PIO's clock domain.

## Interface
- N_LEDS, 8, number of LED channels (width of command and output buses)
- PWM_BITS, 8, width of PWM counter and per-LED level; MAX = 2^PWM_BITS-1
- STEP_DIV, 1024, clock cycles between level steps; legal range >= 1
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- led_cmd  input  N_LEDS  target state per LED (1 = on, 0 = off), from PIO output port, same clock domain
- led_out  output  N_LEDS  registered PWM drive to LED pins, 1 = lit
- fading  output  1  registered; 1 while any LED level differs from its target

## Operation
- cmd_q: led_cmd registered once. All decisions use cmd_q, never raw led_cmd.
- pwm_cnt: PWM_BITS free-running up-counter, +1 every cycle, wraps MAX->0.
- div_cnt: counts 0..STEP_DIV-1 then wraps to 0.
  - step_tick = (div_cnt == STEP_DIV-1).
  - With STEP_DIV=1, div_cnt stays 0 and step_tick is high every cycle.
- level[i]: PWM_BITS, updated only on step_tick:
  - cmd_q[i]=1 and level<MAX -> level+1
  - cmd_q[i]=0 and level>0 -> level-1
  - otherwise hold; saturates at 0 and MAX, no wrap.
- Implied per-LED states, derived from level and cmd_q (no separate state register):
  - OFF: level=0, cmd=0
  - RAMP_UP: cmd=1, level<MAX
  - ON: level=MAX, cmd=1
  - RAMP_DOWN: cmd=0, level>0
  - A cmd change in any state moves the LED to the opposite ramp from its current level. Levels never jump.
- led_out[i] next value:
  - 1 if level[i]==MAX (solid on, no PWM gap)
  - else (level[i] > pwm_cnt)
  - level 0 is therefore solid off. Duty cycle is level/2^PWM_BITS for 0<level<MAX.
- fading next value = OR over i of (level[i] != (cmd_q[i] ? MAX : 0)).
- All LEDs share pwm_cnt and step_tick, so LEDs ramping the same way stay in lockstep.

## Timing
- Reset values: cmd_q=0, pwm_cnt=0, div_cnt=0, all level=0, led_out=0, fading=0.
- Reset asserted mid-ramp: everything returns to reset values on the next edge. First step_tick after release is STEP_DIV cycles later.
- Command latency:
  - led_cmd change at edge t is captured in cmd_q at t+1.
  - fading rises at t+2.
  - First level change occurs on the first step_tick at or after t+1.
- Full ramp 0->MAX takes exactly MAX step_ticks: MAX*STEP_DIV cycles, plus up to STEP_DIV-1 cycles of phase.
- led_out lags level/pwm_cnt by one register stage. fading lags level by one cycle.
- A cmd pulse shorter than STEP_DIV that falls between step_ticks has no effect on level. This is intended deglitching.
- Simultaneous cmd change and step_tick: the step uses the old cmd_q. The new value applies from the next step_tick.

## Test plan
- Reset: hold reset 3 cycles with led_cmd=8'hFF -> led_out=0, fading=0 throughout. After release, first level increment occurs exactly STEP_DIV cycles later.
- Ramp up (PWM_BITS=4, STEP_DIV=4): led_cmd=8'h01 -> fading high 2 cycles later. level[0] reaches 15 after 60 cycles plus phase. Once level=15, led_out[0] is solid 1 and fading drops.
- Duty check: freeze at level[0]=5 (PWM_BITS=4) -> led_out[0] high exactly 5 of every 16 cycles; other LEDs stay 0.
- Reversal: ramp LED3 up to level 7, then set led_cmd[3]=0 -> level goes 7,6,...,0 on successive step_ticks with no jump. led_out[3] ends solid 0, fading falls.
- Glitch: 1-cycle pulse on led_cmd[5] between step_ticks (STEP_DIV=16) -> level[5] stays 0, led_out[5] stays 0.
- Saturation/mixed: led_cmd=8'hA5 held 2*MAX*STEP_DIV cycles -> levels for bits 0,2,5,7 pinned at MAX, others pinned at 0, no wrap. Then reset mid-way through a new ramp -> all outputs return to 0 next edge.
